sdp_bram_arbiter: RTL and testbench

- Shares one simple-dual-port BRAM (one write port, one read port, synchronous 1-cycle registered read) between two write clients and two read clients.
- Per-port round-robin arbitration, valid/ready request handshakes, and a tagged read-return pipeline.
- Guarantees the BRAM never sees a same-cycle write and read of the same address, because that case is undefined for the SDP primitive.
- Sits between client logic and the inferred/mapped SDP BRAM.

---
 rtl/sdp_bram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdp_bram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_bram_arbiter.sv
// Two-writer / two-reader round-robin front end for a simple-dual-port BRAM with 1-cycle read.
// Optional macro SDP_ARB_BYPASS_EN: forward same-cycle write data to a colliding read instead of stalling it.
module sdp_bram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w1_ready,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic [ADDR_W-1:0] mem_ra,
    input  logic [DATA_W-1:0] mem_rd
);

    // Handshake: a request transfers in any cycle where valid && ready; ready is
    // combinational, never raised without valid, and the client holds its payload until then.

    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic              w_gnt0, w_gnt1, w_acc;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_blk0, r_blk1, r_cand0, r_cand1;
    logic              r_gnt0, r_gnt1, r_acc;
    logic [ADDR_W-1:0] r_addr;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_wa_q, mem_ra_q;
    logic [DATA_W-1:0] mem_wd_q;
    logic              s1_vld_q, s1_tag_q, s2_vld_q, s2_tag_q;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        w_gnt0 = w0_valid & (~w1_valid | ~wptr_q);
        w_gnt1 = w1_valid & (~w0_valid | wptr_q);
        w_acc  = w_gnt0 | w_gnt1;
        w_addr = w_gnt1 ? w1_addr : w0_addr;
        w_data = w_gnt1 ? w1_data : w0_data;
        wptr_d = (w0_valid & w1_valid) ? ~wptr_q : wptr_q;
    end

`ifdef SDP_ARB_BYPASS_EN
    assign r_blk0 = 1'b0;
    assign r_blk1 = 1'b0;
`else
    // A read sharing the address of this cycle's write would hit the BRAM in the same cycle.
    assign r_blk0 = w_acc && (r0_addr == w_addr);
    assign r_blk1 = w_acc && (r1_addr == w_addr);
`endif

    always_comb begin
        r_cand0 = r0_valid & ~r_blk0;
        r_cand1 = r1_valid & ~r_blk1;
        r_gnt0  = r_cand0 & (~r_cand1 | ~rptr_q);
        r_gnt1  = r_cand1 & (~r_cand0 | rptr_q);
        r_acc   = r_gnt0 | r_gnt1;
        r_addr  = r_gnt1 ? r1_addr : r0_addr;
        rptr_d  = (r_cand0 & r_cand1) ? ~rptr_q : rptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_wa_q <= '0;
            mem_wd_q <= '0;
            mem_ra_q <= '0;
            s1_vld_q <= 1'b0;
            s1_tag_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_tag_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            mem_we_q <= w_acc;
            if (w_acc) begin
                mem_wa_q <= w_addr;
                mem_wd_q <= w_data;
            end
            if (r_acc) begin
                mem_ra_q <= r_addr;
            end
            s1_vld_q <= r_acc;
            s1_tag_q <= r_gnt1;
            s2_vld_q <= s1_vld_q;
            s2_tag_q <= s1_tag_q;
        end
    end

`ifdef SDP_ARB_BYPASS_EN
    logic              s1_byp_q, s2_byp_q;
    logic [DATA_W-1:0] s1_bdata_q, s2_bdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_byp_q   <= 1'b0;
            s2_byp_q   <= 1'b0;
            s1_bdata_q <= '0;
            s2_bdata_q <= '0;
        end else begin
            s1_byp_q   <= r_acc && w_acc && (r_addr == w_addr);
            s1_bdata_q <= w_data;
            s2_byp_q   <= s1_byp_q;
            s2_bdata_q <= s1_bdata_q;
        end
    end

    // The BRAM output for a collided slot is undefined, so it is replaced outright.
    assign ret_data = s2_byp_q ? s2_bdata_q : mem_rd;
`else
    assign ret_data = mem_rd;
`endif

    assign w0_ready  = w_gnt0;
    assign w1_ready  = w_gnt1;
    assign r0_ready  = r_gnt0;
    assign r1_ready  = r_gnt1;
    assign mem_we    = mem_we_q;
    assign mem_wa    = mem_wa_q;
    assign mem_wd    = mem_wd_q;
    assign mem_ra    = mem_ra_q;
    assign r0_rvalid = s2_vld_q & ~s2_tag_q;
    assign r1_rvalid = s2_vld_q & s2_tag_q;
    assign r0_rdata  = ret_data;
    assign r1_rdata  = ret_data;

endmodule

// File: tb/tb_sdp_bram_arbiter.sv
// Bench for sdp_bram_arbiter: BRAM model, directed grant/hazard/reset cases, random traffic with a
// scoreboard of expected read data and return cycle per client.
module tb_sdp_bram_arbiter;
    localparam int AW = 10;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          w0_valid, w1_valid, r0_valid, r1_valid;
    logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          w0_ready, w1_ready, r0_ready, r1_ready;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_wa, mem_ra;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [DW-1:0] bram    [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int            due0_q[$];
    int            due1_q[$];
    int            n_checks = 0;
    int            n_errs = 0;
    int            cyc = 0;

    sdp_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
        .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_ready(r0_ready),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_ready(r1_ready),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_rd(mem_rd)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit, errors=%0d", n_errs);
        $fatal(1, "timeout");
    end

    // BRAM model: a same-cycle collision returns all ones so undefined data is visible
    always @(posedge clk) begin
        if (mem_we) bram[mem_wa] <= mem_wd;
        if (mem_we && mem_wa == mem_ra) mem_rd <= '1;
        else                            mem_rd <= bram[mem_ra];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: returns are checked first, then this cycle's accepts are recorded
    always @(negedge clk) begin
        logic          wacc;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        cyc++;
        if (rst) begin
            exp0_q.delete(); exp1_q.delete(); due0_q.delete(); due1_q.delete();
        end else begin
            if (r0_rvalid) begin
                if (exp0_q.size() == 0) check("r0_unexpected_rvalid", 1, 0);
                else begin
                    check("r0_rdata", r0_rdata, exp0_q.pop_front());
                    check("r0_latency", cyc, due0_q.pop_front());
                end
            end
            if (r1_rvalid) begin
                if (exp1_q.size() == 0) check("r1_unexpected_rvalid", 1, 0);
                else begin
                    check("r1_rdata", r1_rdata, exp1_q.pop_front());
                    check("r1_latency", cyc, due1_q.pop_front());
                end
            end
            wacc  = (w0_valid && w0_ready) || (w1_valid && w1_ready);
            waddr = (w1_valid && w1_ready) ? w1_addr : w0_addr;
            wdata = (w1_valid && w1_ready) ? w1_data : w0_data;
            if (r0_valid && r0_ready) begin
                exp0_q.push_back((wacc && waddr == r0_addr) ? wdata : ref_mem[r0_addr]);
                due0_q.push_back(cyc + 2);
            end
            if (r1_valid && r1_ready) begin
                exp1_q.push_back((wacc && waddr == r1_addr) ? wdata : ref_mem[r1_addr]);
                due1_q.push_back(cyc + 2);
            end
            if (wacc) ref_mem[waddr] = wdata;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_valid = 1'b0; w1_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    initial begin
        logic w0_ok, w1_ok, r0_ok, r1_ok;
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end
        mem_rd = '0;
        w0_addr = '0; w1_addr = '0; r0_addr = '0; r1_addr = '0;
        w0_data = '0; w1_data = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wa", mem_wa, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_mem_ra", mem_ra, 0);
        check("rst_r0_rvalid", r0_rvalid, 0);
        check("rst_r1_rvalid", r1_rvalid, 0);
        rst = 1'b0;
        step();

        // single write while idle
        w0_valid = 1'b1; w0_addr = 10'd5; w0_data = 18'h2A5;
        #1;
        check("wr_w0_ready", w0_ready, 1);
        check("wr_w1_ready", w1_ready, 0);
        step();
        w0_valid = 1'b0;
        #1;
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_wa", mem_wa, 5);
        check("wr_mem_wd", mem_wd, 18'h2A5);
        step();
        check("wr_mem_we_low", mem_we, 0);
        check("wr_mem_wa_hold", mem_wa, 5);

        // contested writes alternate 0,1,0,1
        w0_valid = 1'b1; w0_addr = 10'd1; w0_data = 18'h111;
        w1_valid = 1'b1; w1_addr = 10'd2; w1_data = 18'h222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_w0_ready", w0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_w1_ready", w1_ready, (i % 2 == 1) ? 1 : 0);
            step();
            check("rr_mem_we", mem_we, 1);
            check("rr_mem_wa", mem_wa, (i % 2 == 0) ? 1 : 2);
        end
        idle();
        step();

        // read back addr 5
        r0_valid = 1'b1; r0_addr = 10'd5;
        #1;
        check("rd_r0_ready", r0_ready, 1);
        check("rd_r1_ready", r1_ready, 0);
        step();
        r0_valid = 1'b0;
        #1;
        check("rd_mem_ra", mem_ra, 5);
        check("rd_r0_rvalid_early", r0_rvalid, 0);
        step();
        check("rd_r0_rvalid", r0_rvalid, 1);
        check("rd_r0_rdata", r0_rdata, 18'h2A5);
        check("rd_r1_rvalid", r1_rvalid, 0);
        step();
        check("rd_r0_rvalid_pulse", r0_rvalid, 0);

        // same-cycle write and read of addr 7
        w0_valid = 1'b1; w0_addr = 10'd7; w0_data = 18'h155;
        r1_valid = 1'b1; r1_addr = 10'd7;
        #1;
        check("hz_w0_ready", w0_ready, 1);
`ifdef SDP_ARB_BYPASS_EN
        check("hz_r1_ready", r1_ready, 1);
        step();
        idle();
        step();
`else
        check("hz_r1_ready_blocked", r1_ready, 0);
        step();
        w0_valid = 1'b0;
        #1;
        check("hz_r1_ready_retry", r1_ready, 1);
        step();
        r1_valid = 1'b0;
        step();
`endif
        check("hz_r1_rvalid", r1_rvalid, 1);
        check("hz_r1_rdata", r1_rdata, 18'h155);
        step();

        // reset with two reads in flight; both pointers are pushed to client 1 first
        w0_valid = 1'b1; w0_addr = 10'd40; w0_data = 18'h001;
        w1_valid = 1'b1; w1_addr = 10'd41; w1_data = 18'h002;
        r0_valid = 1'b1; r0_addr = 10'd5;
        r1_valid = 1'b1; r1_addr = 10'd2;
        #1;
        check("mr_w0_first", w0_ready, 1);
        check("mr_r0_first", r0_ready, 1);
        step();
        w0_valid = 1'b0; r0_valid = 1'b0;
        #1;
        check("mr_w1_second", w1_ready, 1);
        check("mr_r1_second", r1_ready, 1);
        step();
        idle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mr_r0_rvalid", r0_rvalid, 0);
            check("mr_r1_rvalid", r1_rvalid, 0);
            check("mr_mem_we", mem_we, 0);
            step();
            if (i == 1) rst = 1'b0;
        end
        w0_valid = 1'b1; w0_addr = 10'd20; w0_data = 18'h0C3;
        w1_valid = 1'b1; w1_addr = 10'd21; w1_data = 18'h0C4;
        r0_valid = 1'b1; r0_addr = 10'd30;
        r1_valid = 1'b1; r1_addr = 10'd31;
        #1;
        check("mr_wptr_reset", w0_ready, 1);
        check("mr_rptr_reset", r0_ready, 1);
        check("mr_w1_wait", w1_ready, 0);
        check("mr_r1_wait", r1_ready, 0);
        step();
        idle();
        step();
        step();

        // rptr now favours client 1, whose read collides with the write
        w0_valid = 1'b1; w0_addr = 10'd9; w0_data = 18'h0AB;
        r1_valid = 1'b1; r1_addr = 10'd9;
        r0_valid = 1'b1; r0_addr = 10'd3;
        #1;
        check("fb_w0_ready", w0_ready, 1);
`ifdef SDP_ARB_BYPASS_EN
        check("fb_r1_ready", r1_ready, 1);
        check("fb_r0_ready", r0_ready, 0);
        step();
        w0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        check("fb_r0_later", r0_ready, 1);
        step();
        r0_valid = 1'b0;
`else
        check("fb_r1_blocked", r1_ready, 0);
        check("fb_r0_granted", r0_ready, 1);
        step();
        w0_valid = 1'b0; r0_valid = 1'b0;
        #1;
        check("fb_r1_later", r1_ready, 1);
        step();
        r1_valid = 1'b0;
`endif
        step();
        step();

        // random traffic over a small address window; payload held until accepted
        w0_ok = 1'b1; w1_ok = 1'b1; r0_ok = 1'b1; r1_ok = 1'b1;
        repeat (400) begin
            if (!w0_valid || w0_ok) begin
                w0_valid = ($urandom_range(0, 3) != 0);
                w0_addr  = AW'($urandom_range(0, 15));
                w0_data  = DW'($urandom);
            end
            if (!w1_valid || w1_ok) begin
                w1_valid = ($urandom_range(0, 3) != 0);
                w1_addr  = AW'($urandom_range(0, 15));
                w1_data  = DW'($urandom);
            end
            if (!r0_valid || r0_ok) begin
                r0_valid = ($urandom_range(0, 2) != 0);
                r0_addr  = AW'($urandom_range(0, 15));
            end
            if (!r1_valid || r1_ok) begin
                r1_valid = ($urandom_range(0, 2) != 0);
                r1_addr  = AW'($urandom_range(0, 15));
            end
            @(negedge clk);
            w0_ok = w0_ready; w1_ok = w1_ready; r0_ok = r0_ready; r1_ok = r1_ready;
            step();
        end
        idle();
        repeat (5) step();
        check("end_q0_empty", exp0_q.size(), 0);
        check("end_q1_empty", exp1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
